// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with overwrite-oldest overflow
// Define RAS_CKPT_EN to restore tos/cnt from a checkpoint on resteer instead of flushing.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ras_push,
  input  logic            ras_pop,
  input  logic [XLEN-1:0] ras_ret_addr,
  input  logic            resteer,
  input  logic            ras_ckpt,
  output logic [XLEN-1:0] ras_target,
  output logic            ras_target_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic             target_valid_q, target_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;

`ifdef RAS_CKPT_EN
  logic [PTR_W-1:0] ckpt_tos_q, ckpt_tos_d;
  logic [CNT_W-1:0] ckpt_cnt_q, ckpt_cnt_d;
`else
  logic unused_ckpt;
  assign unused_ckpt = ras_ckpt;
`endif

  always_comb begin
    tos_d          = tos_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    target_valid_d = 1'b0;
    overflow_d     = 1'b0;
    underflow_d    = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = tos_q;

    if (resteer) begin
`ifdef RAS_CKPT_EN
      tos_d = ckpt_tos_q;
      cnt_d = ckpt_cnt_q;
`else
      tos_d = TOS_RST;
      cnt_d = '0;
`endif
    end else if (ras_push && ras_pop && cnt_q != '0) begin
      // Return then call: hand out the old top, then replace it in place.
      target_d       = mem_q[tos_q];
      target_valid_d = 1'b1;
      mem_we         = 1'b1;
    end else if (ras_push) begin
      tos_d     = tos_q + 1'b1;
      mem_we    = 1'b1;
      mem_waddr = tos_d;
      if (cnt_q == CNT_MAX) overflow_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (ras_pop) begin
      if (cnt_q != '0) begin
        target_d       = mem_q[tos_q];
        target_valid_d = 1'b1;
        tos_d          = tos_q - 1'b1;
        cnt_d          = cnt_q - 1'b1;
      end else begin
        underflow_d = 1'b1;
      end
    end

    if (rst) mem_we = 1'b0;

`ifdef RAS_CKPT_EN
    ckpt_tos_d = ckpt_tos_q;
    ckpt_cnt_d = ckpt_cnt_q;
    if (ras_ckpt && !resteer) begin
      ckpt_tos_d = tos_d;
      ckpt_cnt_d = cnt_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q          <= TOS_RST;
      cnt_q          <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
`ifdef RAS_CKPT_EN
      ckpt_tos_q     <= '0;
      ckpt_cnt_q     <= '0;
`endif
    end else begin
      tos_q          <= tos_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
`ifdef RAS_CKPT_EN
      ckpt_tos_q     <= ckpt_tos_d;
      ckpt_cnt_q     <= ckpt_cnt_d;
`endif
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= ras_ret_addr;
  end

  assign ras_target       = target_q;
  assign ras_target_valid = target_valid_q;
  assign ras_overflow     = overflow_q;
  assign ras_underflow    = underflow_q;
  assign ras_empty        = (cnt_q == '0);
  assign ras_full         = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - randomized bench for ras_stack against a queue-based reference model
// Honours RAS_CKPT_EN: checkpoint restore is exercised by a directed sequence only.
module tb_ras_stack;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ras_push = 1'b0;
  logic            ras_pop = 1'b0;
  logic [XLEN-1:0] ras_ret_addr = '0;
  logic            resteer = 1'b0;
  logic            ras_ckpt = 1'b0;
  logic [XLEN-1:0] ras_target;
  logic            ras_target_valid;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_overflow;
  logic            ras_underflow;

  ras_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_ret_addr(ras_ret_addr), .resteer(resteer), .ras_ckpt(ras_ckpt),
    .ras_target(ras_target), .ras_target_valid(ras_target_valid),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] q[$];
  logic [XLEN-1:0] ck_q[$];
  logic [XLEN-1:0] e_target = '0;
  logic            e_valid, e_ovf, e_unf;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic p, input logic o, input logic [XLEN-1:0] a,
                      input logic rs, input logic ck, input logic r);
    @(negedge clk);
    ras_push = p; ras_pop = o; ras_ret_addr = a; resteer = rs; ras_ckpt = ck; rst = r;
    e_valid = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    if (r) begin
      q.delete(); ck_q.delete(); e_target = '0;
    end else if (rs) begin
`ifdef RAS_CKPT_EN
      q = ck_q;
`else
      q.delete();
`endif
    end else begin
      if (p && o && q.size() > 0) begin
        e_target = q[$]; e_valid = 1'b1; q[q.size()-1] = a;
      end else if (p) begin
        q.push_back(a);
        if (q.size() > DEPTH) begin q.delete(0); e_ovf = 1'b1; end
      end else if (o) begin
        if (q.size() > 0) begin e_target = q[$]; e_valid = 1'b1; q.delete(q.size()-1); end
        else e_unf = 1'b1;
      end
      if (ck) ck_q = q;
    end
    @(posedge clk);
    #1;
    check("target", ras_target, e_target);
    check("valid", ras_target_valid, e_valid);
    check("overflow", ras_overflow, e_ovf);
    check("underflow", ras_underflow, e_unf);
    check("empty", ras_empty, q.size() == 0);
    check("full", ras_full, q.size() == DEPTH);
  endtask

  task automatic push(input logic [XLEN-1:0] a); step(1, 0, a, 0, 0, 0); endtask
  task automatic pop();                          step(0, 1, 0, 0, 0, 0); endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_target", ras_target, '0);

    push('h100); push('h200); push('h300);
    pop(); check("lifo0", ras_target, 'h300);
    pop(); check("lifo1", ras_target, 'h200);
    pop(); check("lifo2", ras_target, 'h100);
    check("lifo_empty", ras_empty, 1'b1);

    pop(); check("empty_pop_unf", ras_underflow, 1'b1);
    step(0, 0, 0, 0, 0, 0); check("unf_pulse", ras_underflow, 1'b0);

    for (int i = 1; i <= 9; i++) begin
      push(XLEN'(i * 'h10));
      check("ovf_pulse", ras_overflow, i == 9);
    end
    for (int i = 9; i >= 2; i--) begin
      pop(); check("wrap_pop", ras_target, XLEN'(i * 'h10));
    end
    pop(); check("wrap_unf", ras_underflow, 1'b1);

    push('hA0);
    step(1, 1, 'hB0, 0, 0, 0); check("swap_tgt", ras_target, 'hA0);
    pop(); check("swap_new", ras_target, 'hB0);

    step(0, 0, 0, 0, 0, 1);
`ifdef RAS_CKPT_EN
    step(1, 0, 'h40, 0, 1, 0);
    push('h50);
    step(0, 0, 0, 1, 0, 0);
    pop(); check("ckpt_restore", ras_target, 'h40);
`else
    push('h40); push('h50);
    step(1, 0, 'h60, 1, 0, 0);
    check("resteer_flush", ras_empty, 1'b1);
    pop(); check("resteer_drop", ras_underflow, 1'b1);
`endif

    push('h1); push('h2); push('h3);
    step(0, 1, 0, 0, 0, 1);
    check("midrst_valid", ras_target_valid, 1'b0);
    check("midrst_tgt", ras_target, '0);
    check("midrst_empty", ras_empty, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic p, o, rs, ck, r;
      p  = ($urandom_range(0, 99) < 45);
      o  = ($urandom_range(0, 99) < 40);
      ck = ($urandom_range(0, 99) < 20);
`ifdef RAS_CKPT_EN
      rs = 1'b0;
`else
      rs = ($urandom_range(0, 99) < 3);
`endif
      r  = ($urandom_range(0, 999) < 5);
      step(p, o, $urandom, rs, ck, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return-address stack that receives the ras_push / ras_pop / ras_ret_addr requests produced by the D1 decode stage.
- Supplies the predicted return target for the following fetch cycle.
- Circular buffer with top-of-stack pointer and occupancy count; overflow overwrites the oldest entry.
- Resteer either flushes the stack, or restores it to a checkpoint when the optional feature is compiled in.

Parameters:
- XLEN, 32, address width.
- DEPTH, 8, number of entries; must be a power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- ras_push  input  1  call decoded; push ras_ret_addr.
- ras_pop  input  1  return decoded; pop the top entry.
- ras_ret_addr  input  XLEN  return address to push (call PC + 4 from D1).
- resteer  input  1  pipeline redirect; flush or restore.
- ras_ckpt  input  1  capture a checkpoint of pointer and count (branch leaves D1).
- ras_target  output  XLEN  popped return address.
- ras_target_valid  output  1  ras_target is meaningful this cycle.
- ras_empty  output  1  count == 0.
- ras_full  output  1  count == DEPTH.
- ras_overflow  output  1  one-cycle pulse: a push overwrote the oldest entry.
- ras_underflow  output  1  one-cycle pulse: pop on an empty stack.

Behaviour:
- State: mem[DEPTH] of XLEN bits; tos[PTR_W] indexes the top valid entry; cnt ranges 0..DEPTH.
- Reset (rst high at a clk edge):
  - tos = DEPTH-1, so the first push lands in entry 0; cnt = 0.
  - ras_target = 0; ras_target_valid = 0; ras_overflow = 0; ras_underflow = 0.
  - Checkpoint registers cleared.
  - mem contents are not reset.
  - rst has priority over every other input in the same cycle.
- Latency: a pop requested in cycle N drives ras_target / ras_target_valid registered in cycle N+1. ras_target_valid is high for exactly one cycle per successful pop.
- Push only:
  - tos = tos+1 mod DEPTH; mem[tos+1] = ras_ret_addr.
  - If cnt < DEPTH, then cnt+1.
  - Else cnt stays DEPTH and ras_overflow pulses in N+1.
- Pop only, cnt > 0: ras_target = mem[tos]; valid = 1; tos = tos-1 mod DEPTH; cnt-1.
- Pop only, cnt == 0: valid = 0; ras_underflow pulses; tos and cnt unchanged; ras_target holds its old value.
- Push and pop in the same cycle (return followed by call):
  - Output the old mem[tos] (valid only if cnt > 0).
  - Then mem[tos] = ras_ret_addr.
  - tos and cnt unchanged; with cnt == 0 this instead behaves as a push.
  - No overflow is flagged.
- resteer:
  - Overrides push, pop and ras_ckpt in the same cycle.
  - ras_target_valid = 0 in N+1.
  - Without the feature: cnt = 0, tos = DEPTH-1.
- ras_empty and ras_full are combinational from cnt.
- Wrap-around is pure modulo-DEPTH pointer arithmetic; no entry is ever read from outside [tos-cnt+1, tos].

Optional Feature:
- Macro: RAS_CKPT_EN.
- When defined:
  - ras_ckpt high (and resteer low) captures ckpt_tos/ckpt_cnt.
  - The capture uses post-update values if push/pop occur in the same cycle.
  - On resteer: tos = ckpt_tos, cnt = ckpt_cnt.
  - Entry data is not restored; entries overwritten since the checkpoint stay overwritten.
- When undefined: ras_ckpt is ignored, no checkpoint registers exist, and resteer flushes.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300, then three pops → ras_target 0x300, 0x200, 0x100, each valid one cycle after its pop; ras_empty = 1 afterwards.
- Pop on an empty stack → ras_target_valid = 0, ras_underflow = 1 for one cycle, cnt stays 0.
- DEPTH=8: push 0x10..0x90 (9 pushes) → ras_overflow pulses on the 9th; then 8 pops return 0x90 down to 0x20; a 9th pop underflows.
- With 0xA0 on top, simultaneous push 0xB0 + pop → ras_target = 0xA0, cnt unchanged; next pop → 0xB0.
- Push 0x40, 0x50, then resteer plus push in the same cycle → without the macro, ras_empty = 1 and the push is dropped. With RAS_CKPT_EN: ckpt after 0x40, push 0x50, resteer → next pop returns 0x40.
- rst asserted mid-sequence with cnt = 3 and a pop pending → next cycle cnt = 0, ras_target_valid = 0, ras_target = 0.
